dram_arbiter: RTL and testbench

Two-master arbiter that shares the single port of the 8-bit data memory (256-byte space; memory-mapped I/O at 249–255) between the CPU data path (master 0) and a secondary master such as a DMA or debug loader (master 1). It registers one request at a time, drives the memory's address, write-data and write-enable lines for one access cycle, captures read data, and returns a one-cycle acknowledge. Arbitration is round-robin, with a bounded lock for back-to-back accesses by one master.

---
 rtl/dram_arbiter_if.sv | 36 +++
 rtl/dram_arbiter.sv | 139 +++++++++++++
 tb/tb_dram_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: bundles the two master request ports and the memory port
// of the data-memory arbiter.
//   slave  : arbiter side (takes requests and MEM_Q, drives ACK/RDATA/MEM_*/GNT/BUSY)
//   master : surrounding system side (masters and memory model)
interface dram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              M0_REQ,   M1_REQ;
  logic              M0_WE,    M1_WE;
  logic [ADDR_W-1:0] M0_ADDR,  M1_ADDR;
  logic [DATA_W-1:0] M0_WDATA, M1_WDATA;
  logic              M0_LOCK,  M1_LOCK;
  logic              M0_ACK,   M1_ACK;
  logic [DATA_W-1:0] M0_RDATA, M1_RDATA;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_DATA;
  logic              MEM_MW;
  logic [DATA_W-1:0] MEM_Q;
  logic [1:0]        GNT;
  logic              BUSY;

  modport slave (
    input  M0_REQ, M1_REQ, M0_WE, M1_WE, M0_ADDR, M1_ADDR,
           M0_WDATA, M1_WDATA, M0_LOCK, M1_LOCK, MEM_Q,
    output M0_ACK, M1_ACK, M0_RDATA, M1_RDATA,
           MEM_ADDR, MEM_DATA, MEM_MW, GNT, BUSY
  );

  modport master (
    output M0_REQ, M1_REQ, M0_WE, M1_WE, M0_ADDR, M1_ADDR,
           M0_WDATA, M1_WDATA, M0_LOCK, M1_LOCK, MEM_Q,
    input  M0_ACK, M1_ACK, M0_RDATA, M1_RDATA,
           MEM_ADDR, MEM_DATA, MEM_MW, GNT, BUSY
  );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single data-memory port between master 0 (CPU)
// and master 1 (DMA/debug). One access at a time: IDLE picks a winner and
// latches its command, ACCESS drives the memory for one cycle, and the
// following edge returns a one-cycle ACK (plus read data for reads).
// Round-robin on ties, with a bounded lock that lets a master keep the port
// for up to MAX_LOCK extra contested accesses.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : dram_arbiter_if.slave (master requests, memory port, GNT/BUSY)
//
// state  | meaning
// IDLE   | no access in flight; sample REQs, latch winner's command
// ACCESS | memory lines driven for the latched command
module dram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 4
) (
  input logic           CLK,
  input logic           RESET,
  dram_arbiter_if.slave bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

  state_t            state, state_nxt;
  logic [1:0]        gnt, gnt_nxt;
  logic              cmd_we, cmd_we_nxt;
  logic [ADDR_W-1:0] cmd_addr, cmd_addr_nxt;
  logic [DATA_W-1:0] cmd_data, cmd_data_nxt;
  logic              last, last_nxt;          // 0 = master 0 served last
  logic              last_lock, last_lock_nxt;
  logic [3:0]        lock_cnt, lock_cnt_nxt;
  logic              ack0, ack0_nxt, ack1, ack1_nxt;
  logic [DATA_W-1:0] rdata0, rdata0_nxt, rdata1, rdata1_nxt;

  logic win, lock_hold, req_last, other_req, win_lock;

  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    cmd_we_nxt    = cmd_we;
    cmd_addr_nxt  = cmd_addr;
    cmd_data_nxt  = cmd_data;
    last_nxt      = last;
    last_lock_nxt = last_lock;
    lock_cnt_nxt  = lock_cnt;
    ack0_nxt      = 1'b0;
    ack1_nxt      = 1'b0;
    rdata0_nxt    = rdata0;
    rdata1_nxt    = rdata1;

    // Lock override beats round-robin while the streak is below the bound.
    req_last  = last ? bus.M1_REQ : bus.M0_REQ;
    lock_hold = last_lock && req_last && (lock_cnt < MAX_LOCK_C);
    if (lock_hold)
      win = last;
    else if (bus.M0_REQ && bus.M1_REQ)
      win = ~last;
    else
      win = ~bus.M0_REQ;
    other_req = win ? bus.M0_REQ : bus.M1_REQ;
    win_lock  = win ? bus.M1_LOCK : bus.M0_LOCK;

    case (state)
      IDLE: begin
        if (bus.M0_REQ || bus.M1_REQ) begin
          state_nxt     = ACCESS;
          gnt_nxt       = win ? 2'b10 : 2'b01;
          cmd_we_nxt    = win ? bus.M1_WE    : bus.M0_WE;
          cmd_addr_nxt  = win ? bus.M1_ADDR  : bus.M0_ADDR;
          cmd_data_nxt  = win ? bus.M1_WDATA : bus.M0_WDATA;
          last_nxt      = win;
          last_lock_nxt = win_lock;
          // Streak only grows for a contested, still-locked repeat grant.
          lock_cnt_nxt  = (lock_hold && other_req && win_lock) ? lock_cnt + 4'd1 : 4'd0;
        end
      end
      ACCESS: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
        if (gnt[0]) begin
          ack0_nxt = 1'b1;
          if (!cmd_we) rdata0_nxt = bus.MEM_Q;
        end
        if (gnt[1]) begin
          ack1_nxt = 1'b1;
          if (!cmd_we) rdata1_nxt = bus.MEM_Q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      last      <= 1'b1;
      last_lock <= 1'b0;
      lock_cnt  <= 4'd0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      cmd_we    <= cmd_we_nxt;
      cmd_addr  <= cmd_addr_nxt;
      cmd_data  <= cmd_data_nxt;
      last      <= last_nxt;
      last_lock <= last_lock_nxt;
      lock_cnt  <= lock_cnt_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
      rdata0    <= rdata0_nxt;
      rdata1    <= rdata1_nxt;
    end
  end

  assign bus.MEM_ADDR = cmd_addr;
  assign bus.MEM_DATA = cmd_data;
  // The write strobe is masked by RESET so an access abandoned by reset
  // never commits at the edge that ends it.
  assign bus.MEM_MW   = (state == ACCESS) && cmd_we && !RESET;
  assign bus.GNT      = gnt;
  assign bus.BUSY     = (state == ACCESS);
  assign bus.M0_ACK   = ack0;
  assign bus.M1_ACK   = ack1;
  assign bus.M0_RDATA = rdata0;
  assign bus.M1_RDATA = rdata1;

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
  localparam int         MAX_LOCK = 4;
  localparam logic [7:0] IOA = 8'h5A;
  localparam logic [7:0] IOB = 8'hB1;
  localparam logic [7:0] IOC = 8'hC2;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dram_arbiter_if bus ();

  dram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(MAX_LOCK)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory attached to the arbiter ----------------
  logic [7:0] pmem [0:255];
  bit mem_ready;
  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) pmem[i] <= 8'(i) ^ 8'h13;
      mem_ready <= 1'b1;
    end else if (bus.MEM_MW) begin
      pmem[bus.MEM_ADDR] <= bus.MEM_DATA;
    end
  end
  always_comb begin
    if (bus.MEM_ADDR == 8'd249)      bus.MEM_Q = IOA;
    else if (bus.MEM_ADDR == 8'd250) bus.MEM_Q = IOB;
    else if (bus.MEM_ADDR == 8'd251) bus.MEM_Q = IOC;
    else if (bus.MEM_ADDR >= 8'd252) bus.MEM_Q = 8'h00;
    else                             bus.MEM_Q = pmem[bus.MEM_ADDR];
  end

  // ---------------- reference model ----------------
  typedef struct {bit m; bit we; logic [7:0] addr; logic [7:0] data; int t;} grant_t;
  typedef struct {bit m; logic [7:0] rdata; int t;} ack_t;

  grant_t     grant_q[$];
  ack_t       ack_q[$];
  bit         gnt_log[$];
  logic [7:0] ref_mem [0:255];
  logic [7:0] exp_rd [2];
  grant_t     cur;
  int         cyc = 0;
  bit         busy_m = 1'b0;
  bit         last_m = 1'b1;
  bit         last_lock_m = 1'b0;
  int         streak = 0;
  int         mw_cnt = 0;

  initial for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h13;

  function automatic logic [7:0] ref_read(input logic [7:0] a);
    if (a == 8'd249) return IOA;
    if (a == 8'd250) return IOB;
    if (a == 8'd251) return IOC;
    if (a >= 8'd252) return 8'h00;
    return ref_mem[a];
  endfunction

  always @(posedge CLK) begin
    bit r[2];
    bit lk[2];
    bit w, by_lock;
    cyc++;
    r[0] = bus.M0_REQ; r[1] = bus.M1_REQ;
    lk[0] = bus.M0_LOCK; lk[1] = bus.M1_LOCK;
    if (RESET) begin
      busy_m = 0; last_m = 1; last_lock_m = 0; streak = 0;
      exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
      grant_q.delete(); ack_q.delete();
    end else if (busy_m) begin
      if (cur.we) ref_mem[cur.addr] = cur.data;
      else exp_rd[cur.m] = ref_read(cur.addr);
      ack_q.push_back('{m: cur.m, rdata: exp_rd[cur.m], t: cyc});
      busy_m = 0;
    end else if (r[0] || r[1]) begin
      by_lock = last_lock_m && r[last_m] && (streak < MAX_LOCK);
      if (by_lock)          w = last_m;
      else if (r[0] && r[1]) w = !last_m;
      else                  w = r[1];
      streak = (by_lock && r[!w] && lk[w]) ? streak + 1 : 0;
      last_m = w;
      last_lock_m = lk[w];
      cur.m    = w;
      cur.we   = w ? bus.M1_WE : bus.M0_WE;
      cur.addr = w ? bus.M1_ADDR : bus.M0_ADDR;
      cur.data = w ? bus.M1_WDATA : bus.M0_WDATA;
      cur.t    = cyc;
      grant_q.push_back(cur);
      busy_m = 1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    grant_t g;
    ack_t   a;
    if (!RESET && mem_ready) begin
      if (bus.BUSY) begin
        if (grant_q.size() == 0) chk("unexpected_access", 1, 0);
        else begin
          g = grant_q.pop_front();
          gnt_log.push_back(g.m);
          chk("access_cycle", cyc, g.t);
          chk("gnt", bus.GNT, g.m ? 2'b10 : 2'b01);
          chk("mem_addr", bus.MEM_ADDR, g.addr);
          chk("mem_data", bus.MEM_DATA, g.data);
          chk("mem_mw", bus.MEM_MW, g.we);
          if (bus.MEM_MW) mw_cnt++;
        end
      end else begin
        chk("idle_gnt_mw", {bus.GNT, bus.MEM_MW}, 3'b000);
      end
      if (bus.M0_ACK || bus.M1_ACK) begin
        chk("ack_exclusive", bus.M0_ACK & bus.M1_ACK, 0);
        if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          a = ack_q.pop_front();
          chk("ack_owner", bus.M1_ACK, a.m);
          chk("ack_cycle", cyc, a.t);
          chk("rdata", a.m ? bus.M1_RDATA : bus.M0_RDATA, a.rdata);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input bit m, input bit req, input bit we, input logic [7:0] addr,
                       input logic [7:0] data, input bit lock);
    if (!m) begin
      bus.M0_REQ = req; bus.M0_WE = we; bus.M0_ADDR = addr; bus.M0_WDATA = data; bus.M0_LOCK = lock;
    end else begin
      bus.M1_REQ = req; bus.M1_WE = we; bus.M1_ADDR = addr; bus.M1_WDATA = data; bus.M1_LOCK = lock;
    end
  endtask

  task automatic txn(input bit m, input bit we, input logic [7:0] addr,
                     input logic [7:0] data, input bit lock);
    bit done = 0;
    drive(m, 1'b1, we, addr, data, lock);
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge CLK); #1;
      done = m ? bus.M1_ACK : bus.M0_ACK;
    end
    if (!done) chk("txn_timeout", 0, 1);
    drive(m, 1'b0, we, addr, data, 1'b0);
  endtask

  task automatic burst(input bit m, input int n, input bit lock);
    for (int i = 0; i < n; i++) txn(m, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom), lock);
  endtask

  task automatic rand_master(input bit m, input int n);
    for (int i = 0; i < n; i++) begin
      txn(m, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom),
          $urandom_range(0, 2) == 0);
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    drive(0, 0, 0, 8'h00, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 8'h00, 0);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    chk("rst_gnt", bus.GNT, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_ack", {bus.M0_ACK, bus.M1_ACK}, 0);
    chk("rst_rdata", {bus.M0_RDATA, bus.M1_RDATA}, 0);
    chk("rst_mem", {bus.MEM_ADDR, bus.MEM_DATA, bus.MEM_MW}, 0);

    // single read
    txn(0, 1'b0, 8'd4, 8'hEE, 1'b0);
    chk("single_read_rdata", bus.M0_RDATA, 8'h17);

    // write then read back
    mw_cnt = 0;
    txn(1, 1'b1, 8'd100, 8'hA5, 1'b0);
    txn(1, 1'b0, 8'd100, 8'h00, 1'b0);
    chk("readback_m1", bus.M1_RDATA, 8'hA5);
    chk("readback_m0_kept", bus.M0_RDATA, 8'h17);
    chk("write_mw_cycles", mw_cnt, 1);

    // I/O passthrough
    txn(0, 1'b1, 8'd253, 8'h3C, 1'b0);
    chk("ioe_value", pmem[253], 8'h3C);
    txn(1, 1'b0, 8'd249, 8'h00, 1'b0);
    chk("ioa_read", bus.M1_RDATA, IOA);

    // round-robin tie
    do_reset();
    gnt_log.delete();
    fork
      burst(0, 4, 1'b0);
      burst(1, 4, 1'b0);
    join
    chk("rr_count", gnt_log.size(), 8);
    for (int i = 0; i < gnt_log.size() && i < 8; i++) chk("rr_order", gnt_log[i], i % 2);

    // lock bound
    do_reset();
    gnt_log.delete();
    fork
      burst(0, 6, 1'b1);
      burst(1, 1, 1'b0);
    join
    chk("lock_count", gnt_log.size(), 7);
    for (int i = 0; i < gnt_log.size() && i < 7; i++) chk("lock_order", gnt_log[i], i == 5);

    // reset in the middle of a write access
    drive(0, 1'b1, 1'b1, 8'd10, 8'h77, 1'b0);
    @(posedge CLK); #1;
    chk("pre_reset_busy", bus.BUSY, 1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("abort_no_ack", {bus.M0_ACK, bus.M1_ACK}, 0);
    chk("abort_gnt", bus.GNT, 0);
    chk("abort_busy", bus.BUSY, 0);
    chk("abort_rdata", {bus.M0_RDATA, bus.M1_RDATA}, 0);
    chk("abort_mem", {bus.MEM_ADDR, bus.MEM_DATA, bus.MEM_MW}, 0);
    chk("abort_no_commit", pmem[10], 8'h19);
    gnt_log.delete();
    fork
      txn(0, 1'b0, 8'd20, 8'h00, 1'b0);
      txn(1, 1'b0, 8'd21, 8'h00, 1'b0);
    join
    chk("post_reset_tie", gnt_log.size() > 0 ? gnt_log[0] : 1'b1, 0);

    // randomized traffic
    fork
      rand_master(0, 40);
      rand_master(1, 40);
    join
    repeat (4) @(posedge CLK);
    #1;
    chk("grant_q_drained", grant_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
